// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } meas_state_e;

  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with history flop; emits combinational edge detects
// and registered one-cycle rise/fall strobes for an asynchronous input.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_det_o,
  output logic fall_det_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;
  logic rise_q, fall_q;

  assign rise_det_o = s2_q & ~s3_q;
  assign fall_det_o = ~s2_q & s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise_det_o;
      fall_q <= fall_det_o;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow monitored clock in clk_in cycles,
// flags off-frequency periods and loss of clock.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned EXP_PERIOD = 5,
  parameter int unsigned TOL        = 0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_mon,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             period_err,
  output logic             stalled
);

  localparam int unsigned DEV_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [DEV_W-1:0] EXP_C     = DEV_W'(EXP_PERIOD);
  localparam logic [DEV_W-1:0] TOL_C     = DEV_W'(TOL);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // Absolute deviation from the expected period, one bit wider so it never wraps.
  function automatic logic [DEV_W-1:0] abs_dev(input logic [CNT_W-1:0] c);
    logic [DEV_W-1:0] cx;
    cx = {1'b0, c};
    return (cx >= EXP_C) ? (cx - EXP_C) : (EXP_C - cx);
  endfunction

  logic rise_det, fall_det;

  sync_edge_det u_sync (
    .clk_i      (clk_in),
    .rst_i      (rst),
    .async_i    (clk_mon),
    .rise_det_o (rise_det),
    .fall_det_o (fall_det),
    .rise_o     (rise_pulse),
    .fall_o     (fall_pulse)
  );

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             stalled_q, stalled_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      stalled_q <= stalled_d;
    end
  end

  // Captures use the pre-strobe detect so they land in the same cycle as the strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    err_d     = err_q;
    stalled_d = stalled_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise_det) begin
          cnt_d     = ONE_C;
          state_d   = ARMED;
          stalled_d = 1'b0;
        end
      end
      ARMED, LOCKED: begin
        cnt_d = cnt_q + ONE_C;
        if (fall_det) begin
          high_d = cnt_q;
        end
        if (rise_det) begin
          period_d = cnt_q;
          err_d    = (abs_dev(cnt_q) > TOL_C);
          valid_d  = 1'b1;
          cnt_d    = ONE_C;
          state_d  = LOCKED;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d   = IDLE;
          stalled_d = 1'b1;
          valid_d   = 1'b0;
          err_d     = 1'b0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign valid      = valid_q;
  assign period_err = err_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized and directed bench for clk_period_meter against a timestamp-based
// reference model of the monitored clock's edges.
module tb_clk_period_meter;

  localparam int EXP  = 5;
  localparam int TOLV = 1;
  localparam int TMO  = 64;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        clk_mon;
  logic        rise_pulse, fall_pulse;
  logic [15:0] period, high_time;
  logic        valid, period_err, stalled;

  always #5 clk_in = ~clk_in;

  clk_period_meter #(
    .CNT_W      (16),
    .EXP_PERIOD (EXP),
    .TOL        (TOLV),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .clk_mon    (clk_mon),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .period_err (period_err),
    .stalled    (stalled)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: clk_mon as sampled at each clk_in edge, and
  // measurement results expressed as differences of edge timestamps.
  bit samp[$];
  int t = -1;
  bit m_active, m_rise, m_fall, m_valid, m_err, m_stalled;
  int m_period, m_high, m_last;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  function automatic bit sv(input int i);
    if (i < 0 || i >= samp.size()) return 1'b0;
    return samp[i];
  endfunction

  task automatic model_edge(input bit r, input bit mon);
    int p, dev;
    t++;
    if (r) begin
      samp.push_back(1'b0);
      if (t >= 1) samp[t-1] = 1'b0;
      if (t >= 2) samp[t-2] = 1'b0;
      m_active = 0; m_rise = 0; m_fall = 0; m_valid = 0;
      m_err = 0; m_stalled = 0; m_period = 0; m_high = 0; m_last = 0;
      return;
    end
    samp.push_back(mon);
    // An edge is seen two samples after clk_mon changes.
    m_rise = sv(t-2) && !sv(t-3);
    m_fall = !sv(t-2) && sv(t-3);
    if (!m_active) begin
      if (m_rise) begin
        m_active  = 1;
        m_last    = t;
        m_stalled = 0;
      end
    end else begin
      if (m_fall) m_high = t - m_last;
      if (m_rise) begin
        p        = t - m_last;
        dev      = (p > EXP) ? p - EXP : EXP - p;
        m_period = p;
        m_err    = (dev > TOLV);
        m_valid  = 1;
        m_last   = t;
      end else if (t - m_last == TMO) begin
        m_active  = 0;
        m_stalled = 1;
        m_valid   = 0;
        m_err     = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge(rst, clk_mon);
    @(negedge clk_in);
    expect_eq("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    expect_eq("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    expect_eq("period",     32'(period),     32'(m_period));
    expect_eq("high_time",  32'(high_time),  32'(m_high));
    expect_eq("valid",      32'(valid),      32'(m_valid));
    expect_eq("period_err", 32'(period_err), 32'(m_err));
    expect_eq("stalled",    32'(stalled),    32'(m_stalled));
  endtask

  task automatic wave(input int lo, input int hi, input int n);
    repeat (n) begin
      clk_mon = 1'b0;
      repeat (lo) step();
      clk_mon = 1'b1;
      repeat (hi) step();
    end
  endtask

  initial begin
    int k;
    rst     = 1'b1;
    clk_mon = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    expect_eq("reset_period", 32'(period), 32'd0);
    expect_eq("reset_valid",  32'(valid),  32'd0);

    // Nominal 3-low/2-high divided clock
    wave(3, 2, 8);
    expect_eq("nom_period", 32'(period),     32'd5);
    expect_eq("nom_high",   32'(high_time),  32'd2);
    expect_eq("nom_valid",  32'(valid),      32'd1);
    expect_eq("nom_err",    32'(period_err), 32'd0);

    // Off-frequency: outside, on and beyond the tolerance band
    wave(4, 3, 5);
    expect_eq("off7_period", 32'(period),     32'd7);
    expect_eq("off7_high",   32'(high_time),  32'd3);
    expect_eq("off7_err",    32'(period_err), 32'd1);
    wave(4, 2, 4);
    expect_eq("off6_err",    32'(period_err), 32'd0);
    wave(2, 1, 4);
    expect_eq("off3_period", 32'(period),     32'd3);
    expect_eq("off3_err",    32'(period_err), 32'd1);

    // Stall and recovery
    clk_mon = 1'b0;
    repeat (80) step();
    expect_eq("stall_stalled", 32'(stalled),    32'd1);
    expect_eq("stall_valid",   32'(valid),      32'd0);
    expect_eq("stall_err",     32'(period_err), 32'd0);
    expect_eq("stall_keep",    32'(period),     32'd3);
    wave(3, 2, 4);
    expect_eq("recover_stalled", 32'(stalled), 32'd0);
    expect_eq("recover_valid",   32'(valid),   32'd1);

    // Timeout boundary: period == TIMEOUT measures, TIMEOUT+1 stalls
    wave(60, 4, 3);
    expect_eq("tmo_eq_period",  32'(period),  32'd64);
    expect_eq("tmo_eq_stalled", 32'(stalled), 32'd0);
    wave(61, 4, 2);
    expect_eq("tmo_over_valid", 32'(valid), 32'd0);

    // Reset while locked, with clk_mon high at the reset edge
    wave(3, 2, 4);
    clk_mon = 1'b0;
    step();
    clk_mon = 1'b1;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    expect_eq("rst_valid",  32'(valid),     32'd0);
    expect_eq("rst_period", 32'(period),    32'd0);
    expect_eq("rst_high",   32'(high_time), 32'd0);
    wave(3, 2, 4);
    expect_eq("rst_relock", 32'(valid), 32'd1);

    // One-cycle glitch high
    wave(9, 1, 5);
    expect_eq("glitch_period", 32'(period),    32'd10);
    expect_eq("glitch_high",   32'(high_time), 32'd1);

    // Randomized segments, occasional stalls and resets
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 19);
      if (k == 0) begin
        clk_mon = 1'($urandom_range(0, 1));
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (k == 1) begin
        clk_mon = 1'b0;
        repeat ($urandom_range(60, 70)) step();
      end else begin
        wave($urandom_range(1, 10), $urandom_range(1, 10), 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures an incoming slow clock (for example a divided clock, or an off-chip clock returned to the FPGA) in the fast `clk_in` domain. It synchronizes the monitored clock and emits single-cycle rise and fall strobes. It reports the period and high time in `clk_in` cycles and flags period mismatch or loss of clock. It sits downstream of clock generation logic as the checker and consumer of derived clocks, turning them into clean clock-enable strobes.

## Interface
Parameters:
- CNT_W, 16: width of the measurement counter and of the `period` and `high_time` outputs.
- EXP_PERIOD, 5: expected period in `clk_in` cycles (5 matches 50 MHz to 10 MHz).
- TOL, 0: allowed absolute deviation from EXP_PERIOD.
- TIMEOUT, 1024: cycles without a rise before the clock is declared stalled. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W-1.

Ports:
- clk_in, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: reset, synchronous, active-high.
- clk_mon, input, 1: monitored clock, asynchronous to clk_in.
- rise_pulse, output, 1: one-cycle strobe per detected rising edge of clk_mon.
- fall_pulse, output, 1: one-cycle strobe per detected falling edge of clk_mon.
- period, output, CNT_W: last measured rise-to-rise interval, in cycles.
- high_time, output, CNT_W: last measured rise-to-fall interval, in cycles.
- valid, output, 1: `period` holds a real measurement.
- period_err, output, 1: last period was outside EXP_PERIOD±TOL.
- stalled, output, 1: no rise seen within TIMEOUT cycles.

## Operation
- **Synchronization:** clk_mon passes through a 2-FF synchronizer (s1, s2) plus a history flop s3. Rise = s2 & !s3; fall = !s2 & s3. Both strobes are registered.
- **Counter:** `cnt` increments every cycle while in ARMED or LOCKED. It is held at 0 in IDLE.
- **IDLE** (reset state):
  - On rise: cnt←1, go to ARMED, stalled←0.
  - Falls are ignored.
- **ARMED:**
  - On rise: period←cnt, evaluate period_err, valid←1, cnt←1, go to LOCKED.
- **LOCKED:**
  - On rise: period←cnt, period_err←(|cnt−EXP_PERIOD| > TOL), cnt←1.
- **Falls in ARMED or LOCKED:** high_time←cnt.
- **Timeout:** in ARMED or LOCKED, if cnt==TIMEOUT and no rise occurs that cycle: go to IDLE, stalled←1, valid←0, period_err←0. `period` and `high_time` keep their last values.
- **Simultaneous rise and timeout:** the rise wins. A period equal to TIMEOUT is measured normally.
- **Deviation arithmetic:** compute the deviation in CNT_W+1 bits, with no wrap. Because TIMEOUT ≤ 2^CNT_W-1, cnt cannot overflow.
- **Reset mid-operation:** all state returns to IDLE on the next edge. The synchronizer flops clear to 0, so if clk_mon is high at that point, a rise is detected after reset.

## Timing
- **Reset values:** all outputs are 0; period and high_time are 0; state is IDLE.
- **Strobe latency:** clk_mon high is first sampled at edge n. rise_pulse is high during the cycle after edge n+2, i.e. 3 cycles of latency. fall_pulse has the same latency.
- **Measurement update:** period, valid, and period_err update in the same cycle that rise_pulse is high. high_time updates in the same cycle as fall_pulse.
- **Interval accuracy:** measured intervals are exact in cycles for clk_mon generated synchronously to clk_in. For asynchronous clk_mon they are ±1 cycle.
- **Minimum resolvable pulse:** one clk_in cycle high or low, if it is sampled.
- **Stall timing:** stalled rises TIMEOUT cycles after the last rise_pulse. It clears in the cycle of the next rise_pulse. valid returns on the rise after that.

## Structure
- **Package `clk_meas_pkg`:** the state enum (IDLE, ARMED, LOCKED) and the default CNT_W constant.
- **Sub-module `sync_edge_det`:** the 2-FF synchronizer, history flop, and registered rise/fall strobes. It is reusable for other asynchronous inputs.
- **Top level:** the FSM, the counter, and the capture registers.

## Test plan
1. **Nominal divided clock.** Stimulus: clk_mon synchronous, 3 cycles low then 2 high, repeating; EXP_PERIOD=5, TOL=0. Required: after the second rise, valid=1, period=5, high_time=2, period_err=0. rise_pulse appears every 5 cycles.
2. **Off-frequency clock.** Stimulus: 4 cycles low, 3 high; EXP_PERIOD=5, TOL=1. Required: period=7, high_time=3, period_err=1.
3. **Stall and recovery.** Stimulus: TIMEOUT=64; hold clk_mon low after lock. Required: stalled=1 and valid=0 exactly 64 cycles after the last rise_pulse. On restart, stalled clears at the first rise and valid=1 at the second rise.
4. **Timeout boundary.** Stimulus: TIMEOUT=16. Required: a period of 16 gives period=16 with stalled=0. A period of 17 gives stalled=1.
5. **Reset mid-measurement.** Stimulus: assert rst for 1 cycle while LOCKED. Required: the following cycle has all outputs 0. The next two rises re-establish valid.
6. **Glitch.** Stimulus: clk_mon high for exactly 1 synchronous cycle, then low for 9. Required: rise_pulse and fall_pulse are each high for 1 cycle, high_time=1, and period=10 once LOCKED.
